// File: rtl/spi_master.sv
// SPI mode-0 initiator: one byte per cs frame, MSB first, sck = clk/(2*CLK_DIV).
// Optional SPI_MASTER_BURST_EN lets a new byte chain onto the current cs frame.
module spi_master #(
    parameter int CLK_DIV = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       data_in_valid,
    output logic       data_in_ready,
    output logic [7:0] data_out,
    output logic       data_out_valid,
    output logic       busy,
    output logic       sck,
    output logic       cs,
    output logic       mosi,
    input  logic       miso
);
    localparam int DW = $clog2(CLK_DIV) + 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    typedef enum logic [2:0] {IDLE, LEAD, HIGH, LOW, TRAIL, GAP} state_t;

    state_t        state, state_nx;
    logic [7:0]    tx, rx;
    logic [2:0]    bit_cnt;
    logic [DW-1:0] div_cnt;
    logic          armed;
    logic          phase_end;
    logic          accept;

    assign phase_end = (div_cnt == DIV_LAST);
    assign accept    = data_in_valid && data_in_ready;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx      = state;
        data_in_ready = 1'b0;
        case (state)
            IDLE: begin
                // armed keeps ready low for the first cycle out of reset
                data_in_ready = armed;
                if (data_in_valid && armed) state_nx = LEAD;
            end
            LEAD: if (phase_end) state_nx = HIGH;
            HIGH: begin
`ifdef SPI_MASTER_BURST_EN
                data_in_ready = phase_end && (bit_cnt == 3'd7);
`endif
                if (phase_end) begin
                    if (bit_cnt != 3'd7) state_nx = LOW;
                    else if (accept)     state_nx = LOW;
                    else                 state_nx = TRAIL;
                end
            end
            LOW:   if (phase_end) state_nx = HIGH;
            TRAIL: if (phase_end) state_nx = GAP;
            GAP:   if (phase_end) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx             <= 8'h00;
            rx             <= 8'h00;
            bit_cnt        <= 3'd0;
            div_cnt        <= '0;
            armed          <= 1'b0;
            sck            <= 1'b0;
            cs             <= 1'b1;
            mosi           <= 1'b0;
            busy           <= 1'b0;
            data_out       <= 8'h00;
            data_out_valid <= 1'b0;
        end else begin
            armed          <= 1'b1;
            data_out_valid <= 1'b0;
            div_cnt        <= (state == IDLE || phase_end) ? '0 : div_cnt + DW'(1);
            case (state)
                IDLE: if (accept) begin
                    tx      <= data_in;
                    mosi    <= data_in[7];
                    cs      <= 1'b0;
                    busy    <= 1'b1;
                    bit_cnt <= 3'd0;
                end
                LEAD, LOW: if (phase_end) begin
                    sck <= 1'b1;
                    rx  <= {rx[6:0], miso};
                end
                HIGH: if (phase_end) begin
                    sck <= 1'b0;
                    if (bit_cnt != 3'd7) begin
                        tx      <= {tx[6:0], 1'b0};
                        mosi    <= tx[6];
                        bit_cnt <= bit_cnt + 3'd1;
                    end else if (accept) begin
                        // chained byte: reload without leaving the cs frame
                        tx             <= data_in;
                        mosi           <= data_in[7];
                        bit_cnt        <= 3'd0;
                        data_out       <= rx;
                        data_out_valid <= 1'b1;
                    end
                end
                TRAIL: if (phase_end) begin
                    cs             <= 1'b1;
                    data_out       <= rx;
                    data_out_valid <= 1'b1;
                end
                GAP: if (phase_end) busy <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_master.sv
// Table-driven bench for spi_master: per-cycle traces of a CLK_DIV=2 and a
// CLK_DIV=1 instance are captured and checked against hand-derived timing.
module tb_spi_master;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] din = 8'h00;
    logic vld = 1'b0;
    logic sel = 1'b0;
    logic loop_m = 1'b1;
    logic [7:0] slave_byte = 8'h00;
    logic [3:0] scnt = 4'd0;
    logic miso;

    logic rdy0, dv0, busy0, sck0, cs0, mosi0;
    logic rdy1, dv1, busy1, sck1, cs1, mosi1;
    logic [7:0] dout0, dout1;
    logic vld0, vld1;

    logic t_rdy, t_dv, t_busy, t_sck, t_cs, t_mosi;
    logic [7:0] t_dout;
    logic [2:0] sidx;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic       tr_sck  [0:255];
    logic       tr_cs   [0:255];
    logic       tr_mosi [0:255];
    logic       tr_busy [0:255];
    logic       tr_dv   [0:255];
    logic       tr_rdy  [0:255];
    logic [7:0] tr_dout [0:255];

    always #5 clk = ~clk;

    assign vld0   = vld & ~sel;
    assign vld1   = vld & sel;
    assign t_rdy  = sel ? rdy1  : rdy0;
    assign t_dv   = sel ? dv1   : dv0;
    assign t_busy = sel ? busy1 : busy0;
    assign t_sck  = sel ? sck1  : sck0;
    assign t_cs   = sel ? cs1   : cs0;
    assign t_mosi = sel ? mosi1 : mosi0;
    assign t_dout = sel ? dout1 : dout0;

    // slave model: bit 7 ready at cs fall, next bit shifted out on each sck fall
    always @(posedge t_cs or negedge t_sck) begin
        if (t_cs) scnt <= 4'd0;
        else      scnt <= scnt + 4'd1;
    end
    assign sidx = 3'd7 - scnt[2:0];
    assign miso = loop_m ? t_mosi : slave_byte[sidx];

    spi_master #(.CLK_DIV(2)) u0 (
        .clk(clk), .rst(rst), .data_in(din), .data_in_valid(vld0),
        .data_in_ready(rdy0), .data_out(dout0), .data_out_valid(dv0),
        .busy(busy0), .sck(sck0), .cs(cs0), .mosi(mosi0), .miso(miso));

    spi_master #(.CLK_DIV(1)) u1 (
        .clk(clk), .rst(rst), .data_in(din), .data_in_valid(vld1),
        .data_in_ready(rdy1), .data_out(dout1), .data_out_valid(dv1),
        .busy(busy1), .sck(sck1), .cs(cs1), .mosi(mosi1), .miso(miso));

    typedef struct {
        logic [7:0] tx;
        logic       loop;
        logic [7:0] slave;
        logic [7:0] exp_out;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic rec(input int c);
        tr_sck[c]  = t_sck;
        tr_cs[c]   = t_cs;
        tr_mosi[c] = t_mosi;
        tr_busy[c] = t_busy;
        tr_dv[c]   = t_dv;
        tr_rdy[c]  = t_rdy;
        tr_dout[c] = t_dout;
    endtask

    // cycle 0 = the cycle in which valid is high and accepted
    task automatic run_frame(input logic [7:0] d, input int ncyc);
        @(posedge clk); #1;
        din = d; vld = 1'b1;
        @(negedge clk); rec(0);
        @(posedge clk); #1;
        vld = 1'b0; din = ~d;
        for (int c = 1; c < ncyc; c++) begin
            @(negedge clk); rec(c);
            if (c == 5) din = 8'h5A;
        end
    endtask

    task automatic analyze_frame(input string tag, input int d_div, input logic [7:0] exp_mosi,
                                 input logic [7:0] exp_out, input int ncyc);
        int nr = 0, rise_err = 0, cs_low = 0, bad = 0, ndv = 0, dvc = -1, bfall = -1;
        logic [7:0] mseq = 8'h00;
        logic [7:0] dvv = 8'h00;
        for (int c = 1; c < ncyc; c++) begin
            if (tr_sck[c] && !tr_sck[c-1]) begin
                if (c != 1 + d_div + 2*d_div*nr) rise_err++;
                mseq = {mseq[6:0], tr_mosi[c]};
                nr++;
            end
            if (!tr_cs[c]) cs_low++;
            if (tr_cs[c] && tr_sck[c]) bad++;
            if (tr_dv[c]) begin ndv++; dvc = c; dvv = tr_dout[c]; end
            if (bfall < 0 && tr_busy[c-1] && !tr_busy[c]) bfall = c;
        end
        check({tag, " ready_c0"},   int'(tr_rdy[0]), 1);
        check({tag, " busy_c1"},    int'(tr_busy[1]), 1);
        check({tag, " rises"},      nr, 8);
        check({tag, " rise_time"},  rise_err, 0);
        check({tag, " mosi_bits"},  int'(mseq), int'(exp_mosi));
        check({tag, " cs_low"},     cs_low, 17*d_div);
        check({tag, " sck_cs_hi"},  bad, 0);
        check({tag, " dv_count"},   ndv, 1);
        check({tag, " dv_cycle"},   dvc, 1 + 17*d_div);
        check({tag, " data_out"},   int'(dvv), int'(exp_out));
        check({tag, " busy_fall"},  bfall, 1 + 18*d_div);
        check({tag, " dout_hold"},  int'(tr_dout[ncyc-1]), int'(exp_out));
    endtask

    // streaming: valid held, next byte presented after each accept
    task automatic run_stream(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                              input int nb, input int ncyc);
        int k = 0;
        logic acc;
        @(posedge clk); #1;
        din = b0; vld = 1'b1;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk); rec(c);
            acc = t_rdy && vld;
            @(posedge clk); #1;
            if (acc) begin
                k++;
                if (k >= nb) begin vld = 1'b0; din = 8'hE7; end
                else din = (k == 1) ? b1 : b2;
            end
        end
    endtask

    task automatic analyze_stream(input string tag, input int d_div, input int ncyc,
                                  input int exp_win, input int exp_rises, input int exp_dv,
                                  input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2,
                                  input bit cont);
        int win = 0, rises = 0, sp_err = 0, last_rise = -1, min_hi = 1000, hi_run = 0, dvn = 0;
        logic [7:0] dvv [0:2];
        dvv[0] = 8'h00; dvv[1] = 8'h00; dvv[2] = 8'h00;
        for (int c = 1; c < ncyc; c++) begin
            if (tr_cs[c-1] && !tr_cs[c]) begin
                win++;
                if (win > 1 && hi_run < min_hi) min_hi = hi_run;
            end
            hi_run = tr_cs[c] ? hi_run + 1 : 0;
            if (tr_sck[c] && !tr_sck[c-1]) begin
                if (last_rise >= 0 && c - last_rise != 2*d_div) sp_err++;
                last_rise = c;
                rises++;
            end
            if (tr_dv[c]) begin
                if (dvn < 3) dvv[dvn] = tr_dout[c];
                dvn++;
            end
        end
        check({tag, " cs_windows"}, win, exp_win);
        check({tag, " rises"},      rises, exp_rises);
        check({tag, " dv_count"},   dvn, exp_dv);
        check({tag, " dv0"},        int'(dvv[0]), int'(e0));
        check({tag, " dv1"},        int'(dvv[1]), int'(e1));
        if (exp_dv > 2) check({tag, " dv2"}, int'(dvv[2]), int'(e2));
        if (cont) check({tag, " sck_spacing"}, sp_err, 0);
        else      check({tag, " cs_gap_min"},  int'(min_hi >= d_div), 1);
    endtask

    vec_t tbl [4];

    initial begin
        tbl[0] = '{tx: 8'hA5, loop: 1'b1, slave: 8'h00, exp_out: 8'hA5};
        tbl[1] = '{tx: 8'h00, loop: 1'b0, slave: 8'h3C, exp_out: 8'h3C};
        tbl[2] = '{tx: 8'hC3, loop: 1'b0, slave: 8'h5A, exp_out: 8'h5A};
        tbl[3] = '{tx: 8'h01, loop: 1'b1, slave: 8'h00, exp_out: 8'h01};

        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst sck",   int'(sck0), 0);
        check("rst cs",    int'(cs0), 1);
        check("rst mosi",  int'(mosi0), 0);
        check("rst busy",  int'(busy0), 0);
        check("rst ready", int'(rdy0), 0);
        check("rst dout",  int'(dout0), 0);
        check("rst dv",    int'(dv0), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        sel = 1'b0;
        for (int i = 0; i < 4; i++) begin
            loop_m = tbl[i].loop;
            slave_byte = tbl[i].slave;
            run_frame(tbl[i].tx, 42);
            analyze_frame($sformatf("vec%0d", i), 2, tbl[i].tx, tbl[i].exp_out, 42);
        end

        // reset mid-transfer: rst high during cycle 15
        loop_m = 1'b1;
        @(posedge clk); #1;
        din = 8'hA5; vld = 1'b1;
        @(posedge clk); #1;
        vld = 1'b0;
        repeat (14) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort cs",   int'(cs0), 1);
        check("abort sck",  int'(sck0), 0);
        check("abort mosi", int'(mosi0), 0);
        check("abort busy", int'(busy0), 0);
        check("abort dv",   int'(dv0), 0);
        begin
            int spur = 0;
            for (int c = 0; c < 40; c++) begin
                @(negedge clk);
                if (dv0 || !cs0) spur++;
            end
            check("abort no_dv", spur, 0);
        end
        check("abort dout", int'(dout0), 0);
        run_frame(8'h69, 42);
        analyze_frame("after_rst", 2, 8'h69, 8'h69, 42);

        // CLK_DIV=1 instance
        sel = 1'b1;
        run_frame(8'hFF, 24);
        analyze_frame("div1", 1, 8'hFF, 8'hFF, 24);
        check("div1 sck_toggle", int'(tr_sck[2] && !tr_sck[3] && tr_sck[4]), 1);
        sel = 1'b0;
        repeat (4) @(posedge clk);

`ifdef SPI_MASTER_BURST_EN
        run_stream(8'h12, 8'h34, 8'h56, 3, 110);
        analyze_stream("burst", 2, 110, 1, 24, 3, 8'h12, 8'h34, 8'h56, 1'b1);
        check("burst dv_first", int'(tr_dv[33]), 1);
        check("burst dv_last",  int'(tr_dv[99]), 1);
`else
        run_stream(8'h01, 8'h80, 8'h00, 2, 90);
        analyze_stream("hold", 2, 90, 2, 16, 2, 8'h01, 8'h80, 8'h00, 1'b0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no completion, expected finish");
        $fatal(1, "timeout");
    end
endmodule
